// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   UartFifoDepth  : default buffer depth (power of two, >= 2)
//   UartByteCycles : default clocks per byte on the line (start + 8 data + stop)
//   tx_state_e     : pacing FSM state encoding
package uart_tx_scheduler_pkg;

  localparam int unsigned UartFifoDepth  = 16;
  localparam int unsigned UartByteCycles = 10850;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } tx_state_e;

endpackage

// File: rtl/uart_tx_scheduler_sync_fifo.sv
// Synchronous FIFO used as the UART transmit buffer.
// A push is accepted when there is room, or when a pop happens in the
// same cycle (this also covers the full case). Pop must only be requested
// when the FIFO is non-empty.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push_i    : push request (qualified internally against full/pop)
//   pop_i     : pop request (caller guarantees non-empty)
//   wdata_i   : data written at the tail on an accepted push
//   rdata_o   : data at the head (combinational)
//   count_o   : occupancy, 0..DEPTH
//   full_o    : count_o == DEPTH
//   empty_o   : count_o == 0
module uart_tx_scheduler_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_acc;

  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign rdata_o  = mem_q[rd_ptr_q];
  assign push_acc = push_i && (!full_o || pop_i);

  // Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)    rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_acc, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; contents are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Buffers bytes stored to the UART address and paces them into the uart
// transmitter, one byte per byte-time. The uart has no busy output, so
// this block owns the line timing: after each start pulse it waits
// BYTE_CYCLES clocks before issuing the next one.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (shared with uart)
//   wr_en      : push request from the MA-stage store decode
//   wr_data    : byte to transmit
//   stall      : buffer full; core must hold the store
//   uart_wr_o  : one-cycle start pulse to the uart (registered)
//   uart_dat_o : byte to the uart, valid with uart_wr_o (registered)
//   busy       : FIFO non-empty or a byte is on the line
//   count      : FIFO occupancy
//   overflow   : sticky, set when a push was dropped
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH       = UartFifoDepth,
  parameter int unsigned BYTE_CYCLES = UartByteCycles
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   stall,
  output logic                   uart_wr_o,
  output logic [7:0]             uart_dat_o,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned TW = $clog2(BYTE_CYCLES);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          uart_wr_q, uart_wr_d;
  logic [7:0]    uart_dat_q, uart_dat_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;

  uart_tx_scheduler_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .wdata_i (wr_data),
    .rdata_o (fifo_rdata),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A push into a full FIFO survives only if a pop frees the slot this cycle.
  assign drop       = wr_en && fifo_full && !pop;
  assign overflow_d = overflow_q || drop;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      uart_wr_q  <= 1'b0;
      uart_dat_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      uart_wr_q  <= uart_wr_d;
      uart_dat_q <= uart_dat_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state logic. The pulse cycle itself counts as the first cycle of
  // the byte-time, so loading BYTE_CYCLES-1 and leaving at 1 gives exactly
  // BYTE_CYCLES clocks between start pulses.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StWait;
          timer_d = TW'(BYTE_CYCLES - 1);
        end
      end
      StWait: begin
        if (timer_q == TW'(1)) begin
          state_d = StIdle;
        end
        timer_d = timer_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: pop and the registered start pulse/data.
  always_comb begin
    pop        = 1'b0;
    uart_wr_d  = 1'b0;
    uart_dat_d = uart_dat_q;
    if (state_q == StIdle && !fifo_empty) begin
      pop        = 1'b1;
      uart_wr_d  = 1'b1;
      uart_dat_d = fifo_rdata;
    end
  end

  assign stall      = fifo_full;
  assign uart_wr_o  = uart_wr_q;
  assign uart_dat_o = uart_dat_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q == StWait) || !fifo_empty;

endmodule
